// File: rtl/test_pulse_writer_pkg.sv
// Shared types and defaults for the detector test-pulse writer.
// Holds the FSM state encoding, parameter defaults and a burst-length helper.
package test_pulse_writer_pkg;

  localparam int DATA_WIDTH_DEF  = 64;
  localparam int GROUP_WIDTH_DEF = 16;
  localparam int CNTR_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Busy cycles for one burst, including the single DONE cycle.
  function automatic int unsigned burst_len(input int unsigned width,
                                            input int unsigned gap,
                                            input int unsigned count);
    int unsigned w_eff;
    w_eff = (width == 0) ? 1 : width;
    if (count == 0) return 1;
    return count * w_eff + (count - 1) * gap + 1;
  endfunction

endpackage

// File: rtl/test_pulse_writer_cntr.sv
// Clearable up-counter with a terminal flag that is high in the cycle whose
// increment would reach 'limit'; the compare is one bit wider so no wrap occurs.
module test_pulse_writer_cntr
  import test_pulse_writer_pkg::*;
#(
  parameter int W = CNTR_WIDTH_DEF
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] value;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

  assign last = (({1'b0, value} + 1'b1) == {1'b0, limit});

endmodule

// File: rtl/test_pulse_writer.sv
// Test-pulse burst generator for the detector input path.
// Optional walk mode (rotating channel groups) is built when TEST_PULSE_WRITER_WALK_EN is defined.
module test_pulse_writer
  import test_pulse_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int GROUP_WIDTH = GROUP_WIDTH_DEF,
  parameter int CNTR_WIDTH  = CNTR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [CNTR_WIDTH-1:0] width,
  input  logic [CNTR_WIDTH-1:0] gap,
  input  logic [CNTR_WIDTH-1:0] count,
`ifdef TEST_PULSE_WRITER_WALK_EN
  input  logic                  walk,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
  logic [CNTR_WIDTH-1:0]   width_q, gap_q, count_q;
  logic [CNTR_WIDTH-1:0]   width_eff, phase_limit;
  logic                    accept;
  logic                    phase_clr, phase_inc, phase_last;
  logic                    pulse_clr, pulse_inc, pulse_last;
`ifdef TEST_PULSE_WRITER_WALK_EN
  logic                    walk_q;
  logic [DATA_WIDTH-1:0]   pattern_rot;

  assign pattern_rot = {pattern_q[DATA_WIDTH-GROUP_WIDTH-1:0],
                        pattern_q[DATA_WIDTH-1 -: GROUP_WIDTH]};
`endif

  assign width_eff   = (width_q == '0) ? CNTR_WIDTH'(1) : width_q;
  assign phase_limit = (state_q == GAP) ? gap_q : width_eff;

  // Phase counter times the current PULSE or GAP; pulse counter counts finished pulses.
  test_pulse_writer_cntr #(.W(CNTR_WIDTH)) u_phase_cntr (
    .aclk   (aclk),
    .areset (areset),
    .clr    (phase_clr),
    .inc    (phase_inc),
    .limit  (phase_limit),
    .last   (phase_last)
  );

  test_pulse_writer_cntr #(.W(CNTR_WIDTH)) u_pulse_cntr (
    .aclk   (aclk),
    .areset (areset),
    .clr    (pulse_clr),
    .inc    (pulse_inc),
    .limit  (count_q),
    .last   (pulse_last)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    accept    = 1'b0;
    phase_clr = 1'b1;
    phase_inc = 1'b0;
    pulse_clr = 1'b0;
    pulse_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        pulse_clr = 1'b1;
        if (start) begin
          accept    = 1'b1;
          pattern_d = pattern;
          state_d   = (count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (phase_last) begin
          pulse_inc = 1'b1;
          if (pulse_last) begin
            state_d = DONE;
          end else begin
`ifdef TEST_PULSE_WRITER_WALK_EN
            if (walk_q) pattern_d = pattern_rot;
`endif
            state_d = (gap_q == '0) ? PULSE : GAP;
          end
        end else begin
          phase_clr = 1'b0;
          phase_inc = 1'b1;
        end
      end
      GAP: begin
        if (phase_last) begin
          state_d = PULSE;
        end else begin
          phase_clr = 1'b0;
          phase_inc = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q.
  // NOTE: the small config registers are reset along with the FSM; they are
  // cheap flops, not a memory array, so reset costs nothing meaningful.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      count_q   <= '0;
`ifdef TEST_PULSE_WRITER_WALK_EN
      walk_q    <= 1'b0;
`endif
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      if (accept) begin
        width_q <= width;
        gap_q   <= gap;
        count_q <= count;
`ifdef TEST_PULSE_WRITER_WALK_EN
        walk_q  <= walk;
`endif
      end
      dout <= (state_d == PULSE) ? pattern_d : '0;
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
    end
  end

endmodule
